// File: rtl/instr_fetch_unit.sv
// Opcode fetch unit: owns the PC and runs the IDLE/ADDR/DATA read transaction into the opcode buffer.
// Optional macro PC_BREAKPOINT_EN adds a PC breakpoint that inhibits fetch starts in IDLE.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          WAIT_MAX   = 4,
  parameter logic [7:0]  NOP_OPCODE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_ready,
`ifdef PC_BREAKPOINT_EN
  input  logic [15:0] bkpt_addr,
  input  logic        bkpt_en,
  output logic        bkpt_hit,
`endif
  output logic [15:0] addr_bus,
  output logic        mem_rd,
  output logic [7:0]  data_bus_out,
  output logic        fetch_valid,
  output logic        busy,
  output logic [15:0] pc,
  output logic        bus_err
);

  localparam int CW = $clog2(WAIT_MAX + 2);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [7:0]      buf_q, buf_d;
  logic            mem_rd_q, mem_rd_d;
  logic            fv_q, fv_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            pend_q, pend_d;
  logic [15:0]     pend_val_q, pend_val_d;

  logic            start_block;
  logic [CW-1:0]   wait_inc;
  logic            load_now;
  logic [15:0]     load_target;

`ifdef PC_BREAKPOINT_EN
  assign bkpt_hit    = (state_q == S_IDLE) && bkpt_en && (pc_q == bkpt_addr);
  assign start_block = bkpt_hit;
`else
  assign start_block = 1'b0;
`endif

  assign wait_inc = wait_q + CW'(1);
  // A load arriving in the completion cycle is the latest one and overrides any older pending value.
  assign load_now    = pend_q | pc_load;
  assign load_target = pc_load ? pc_load_val : pend_val_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    mem_rd_d   = mem_rd_q;
    fv_d       = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    wait_d     = wait_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;

    unique case (state_q)
      S_IDLE: begin
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (fetch_req && !err_q && !start_block) begin
          state_d  = S_ADDR;
          mem_rd_d = 1'b1;
          busy_d   = 1'b1;
          wait_d   = '0;
        end
      end

      S_ADDR: begin
        state_d = S_DATA;
        if (pc_load) begin
          pend_d     = 1'b1;
          pend_val_d = pc_load_val;
        end
      end

      S_DATA: begin
        if (mem_ready) begin
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          busy_d   = 1'b0;
          wait_d   = '0;
          pend_d   = 1'b0;
          if (load_now) begin
            pc_d  = load_target;
            buf_d = NOP_OPCODE;
          end else begin
            pc_d  = pc_q + 16'd1;
            buf_d = mem_data_in;
            fv_d  = 1'b1;
          end
        end else if (wait_inc > WAIT_LIM) begin
          // Timeout: abandon the fetch, keep the PC, drop any pending load.
          state_d  = S_IDLE;
          mem_rd_d = 1'b0;
          busy_d   = 1'b0;
          err_d    = 1'b1;
          wait_d   = '0;
          pend_d   = 1'b0;
        end else begin
          wait_d = wait_inc;
          if (pc_load) begin
            pend_d     = 1'b1;
            pend_val_d = pc_load_val;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        mem_rd_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      buf_q      <= NOP_OPCODE;
      mem_rd_q   <= 1'b0;
      fv_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      mem_rd_q   <= mem_rd_d;
      fv_q       <= fv_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign addr_bus     = pc_q;
  assign pc           = pc_q;
  assign mem_rd       = mem_rd_q;
  assign data_bus_out = buf_q;
  assign fetch_valid  = fv_q;
  assign busy         = busy_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default build, WAIT_MAX=4, RESET_PC=0000).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [7:0]  mem_data_in;
  logic        mem_ready;
  logic [15:0] addr_bus;
  logic        mem_rd;
  logic [7:0]  data_bus_out;
  logic        fetch_valid;
  logic        busy;
  logic [15:0] pc;
  logic        bus_err;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .RESET_PC  (16'h0000),
    .WAIT_MAX  (4),
    .NOP_OPCODE(8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_data_in (mem_data_in),
    .mem_ready   (mem_ready),
    .addr_bus    (addr_bus),
    .mem_rd      (mem_rd),
    .data_bus_out(data_bus_out),
    .fetch_valid (fetch_valid),
    .busy        (busy),
    .pc          (pc),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0000;
    mem_data_in = 8'h00; mem_ready = 1'b1;
    tick(); tick();
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    checks++; if (addr_bus !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", addr_bus); end
    checks++; if ({mem_rd, fetch_valid, busy, bus_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {mem_rd, fetch_valid, busy, bus_err}); end
    checks++; if (data_bus_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_bus_out); end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic_fetch();
    fetch_req = 1'b1; mem_ready = 1'b1; mem_data_in = 8'h3E;
    tick();
    fetch_req = 1'b0;
    checks++; if ({mem_rd, busy, fetch_valid} !== 3'b110) begin errors++; $display("FAIL basic_addr_phase got=%b exp=110", {mem_rd, busy, fetch_valid}); end
    checks++; if (addr_bus !== 16'h0000) begin errors++; $display("FAIL basic_addr got=%h exp=0000", addr_bus); end
    tick();
    checks++; if ({mem_rd, fetch_valid} !== 2'b10) begin errors++; $display("FAIL basic_data_phase got=%b exp=10", {mem_rd, fetch_valid}); end
    tick();
    checks++; if ({fetch_valid, mem_rd, busy} !== 3'b100) begin errors++; $display("FAIL basic_valid got=%b exp=100", {fetch_valid, mem_rd, busy}); end
    checks++; if (data_bus_out !== 8'h3E) begin errors++; $display("FAIL basic_data got=%h exp=3e", data_bus_out); end
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL basic_pc got=%h exp=0001", pc); end
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got=%b exp=0", fetch_valid); end
    $display("fetch addr=0000 data=%h pc=%h", data_bus_out, pc);
  endtask

  task automatic test_wait_states();
    fetch_req = 1'b1; mem_ready = 1'b0; mem_data_in = 8'hA5;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    checks++; if ({fetch_valid, busy} !== 2'b01) begin errors++; $display("FAIL wait1 got=%b exp=01", {fetch_valid, busy}); end
    tick();
    checks++; if ({fetch_valid, busy} !== 2'b01) begin errors++; $display("FAIL wait2 got=%b exp=01", {fetch_valid, busy}); end
    mem_ready = 1'b1;
    tick();
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL wait_valid got=%b exp=1", fetch_valid); end
    checks++; if (data_bus_out !== 8'hA5) begin errors++; $display("FAIL wait_data got=%h exp=a5", data_bus_out); end
    checks++; if (pc !== 16'h0002) begin errors++; $display("FAIL wait_pc got=%h exp=0002", pc); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL wait_err got=%b exp=0", bus_err); end
    tick();
    $display("fetch addr=0001 data=%h pc=%h (2 wait states)", data_bus_out, pc);
  endtask

  task automatic test_pc_load();
    pc_load = 1'b1; pc_load_val = 16'hC000; fetch_req = 1'b1;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    checks++; if (pc !== 16'hC000) begin errors++; $display("FAIL load_pc got=%h exp=c000", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_wins got=%b exp=0", busy); end
    fetch_req = 1'b1; mem_ready = 1'b1; mem_data_in = 8'h77;
    tick();
    fetch_req = 1'b0;
    checks++; if ({addr_bus, mem_rd} !== {16'hC000, 1'b1}) begin errors++; $display("FAIL load_addr got=%h/%b exp=c000/1", addr_bus, mem_rd); end
    tick(); tick();
    checks++; if ({pc, data_bus_out, fetch_valid} !== {16'hC001, 8'h77, 1'b1}) begin errors++; $display("FAIL load_fetch got=%h/%h/%b exp=c001/77/1", pc, data_bus_out, fetch_valid); end
    tick();
    $display("fetch addr=c000 data=%h pc=%h", data_bus_out, pc);
  endtask

  task automatic test_pc_wrap();
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1; mem_ready = 1'b1; mem_data_in = 8'hC9;
    tick();
    fetch_req = 1'b0;
    tick(); tick();
    checks++; if ({pc, fetch_valid} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL wrap_pc got=%h/%b exp=0000/1", pc, fetch_valid); end
    tick();
    $display("fetch addr=ffff data=%h pc=%h", data_bus_out, pc);
  endtask

  task automatic test_pending_load();
    pc_load = 1'b1; pc_load_val = 16'h0100;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1; mem_ready = 1'b0; mem_data_in = 8'h55;
    tick();
    fetch_req = 1'b0;
    tick();
    pc_load = 1'b1; pc_load_val = 16'h0150;
    tick();
    pc_load = 1'b0;
    checks++; if ({pc, busy} !== {16'h0100, 1'b1}) begin errors++; $display("FAIL pend_hold got=%h/%b exp=0100/1", pc, busy); end
    mem_ready = 1'b1;
    tick();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL pend_valid got=%b exp=0", fetch_valid); end
    checks++; if (data_bus_out !== 8'h00) begin errors++; $display("FAIL pend_flush got=%h exp=00", data_bus_out); end
    checks++; if ({pc, busy} !== {16'h0150, 1'b0}) begin errors++; $display("FAIL pend_pc got=%h/%b exp=0150/0", pc, busy); end
    tick();
    $display("fetch addr=0100 flushed by load pc=%h", pc);
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; mem_ready = 1'b0; mem_data_in = 8'h99;
    tick();
    fetch_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_rd, busy, fetch_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {mem_rd, busy, fetch_valid}); end
    checks++; if ({pc, addr_bus} !== 32'h0000_0000) begin errors++; $display("FAIL rstmid_pc got=%h/%h exp=0000/0000", pc, addr_bus); end
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({data_bus_out, pc, busy} !== {8'h00, 16'h0000, 1'b0}) begin errors++; $display("FAIL rstmid_after got=%h/%h/%b exp=00/0000/0", data_bus_out, pc, busy); end
    $display("fetch addr=0150 aborted by reset");
  endtask

  task automatic test_bus_err();
    fetch_req = 1'b1; mem_ready = 1'b0;
    tick();
    fetch_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({bus_err, fetch_valid, busy} !== 3'b001) begin errors++; $display("FAIL err_waiting%0d got=%b exp=001", i, {bus_err, fetch_valid, busy}); end
    end
    tick();
    checks++; if ({bus_err, fetch_valid, busy, mem_rd} !== 4'b1000) begin errors++; $display("FAIL err_timeout got=%b exp=1000", {bus_err, fetch_valid, busy, mem_rd}); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL err_pc got=%h exp=0000", pc); end
    fetch_req = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    fetch_req = 1'b0;
    checks++; if ({busy, mem_rd, bus_err} !== 3'b001) begin errors++; $display("FAIL err_blocks got=%b exp=001", {busy, mem_rd, bus_err}); end
    $display("fetch addr=0000 timed out bus_err=%b", bus_err);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_pc_load();
    test_pc_wrap();
    test_pending_load();
    test_reset_mid();
    test_bus_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream neighbour of the decode stage. Owns the 16-bit program counter and runs the opcode-fetch bus transaction: PC onto the address bus, read strobe, wait-state stretching, opcode byte latched into a buffer. The buffer output feeds decode's data_bus_in, and fetch_valid tells decode a fresh opcode is ready for the next M1. Also accepts absolute PC loads for jumps, calls, returns and interrupts.

Parameters:
RESET_PC, 16'h0000, PC value after reset (boot ROM entry)
WAIT_MAX, 4, maximum consecutive mem_ready-low cycles tolerated in DATA before bus error
NOP_OPCODE, 8'h00, value held in opcode buffer after reset or flush

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
fetch_req  input  1  request one opcode fetch; level, sampled in IDLE only
pc_load  input  1  load PC with pc_load_val (jump/call/ret/irq)
pc_load_val  input  16  new PC value
mem_data_in  input  8  read data from memory/bus
mem_ready  input  1  memory has valid data this cycle
addr_bus  output  16  memory address
mem_rd  output  1  memory read strobe
data_bus_out  output  8  opcode buffer, to decode data_bus_in
fetch_valid  output  1  one-cycle pulse: data_bus_out updated with a new opcode
busy  output  1  fetch transaction in progress
pc  output  16  current program counter
bus_err  output  1  sticky: wait-state timeout occurred

Behaviour:
- Reset (rst high, async): state=IDLE, pc=RESET_PC, data_bus_out=NOP_OPCODE, mem_rd=0, fetch_valid=0, busy=0, bus_err=0, wait counter=0, pending-load flag=0, addr_bus=RESET_PC. Reset mid-transaction aborts immediately; no partial latch.
- addr_bus always equals pc; mem_rd gates the access.
- FSM, all transitions on posedge clk:
  IDLE: busy=0, mem_rd=0. If pc_load=1: pc<=pc_load_val and stay IDLE; fetch_req is ignored that cycle (load wins). Else if fetch_req=1 and bus_err=0: go to ADDR.
  ADDR: busy=1, mem_rd=1. Unconditionally go to DATA.
  DATA: busy=1, mem_rd=1.
    - If mem_ready=1: data_bus_out<=mem_data_in. If no load is pending: pc<=pc+1 and fetch_valid<=1. If a load is pending: pc<=pending value, fetch_valid stays 0, data_bus_out<=NOP_OPCODE (flush). Clear the pending flag and go to IDLE.
    - If mem_ready=0: increment the wait counter. When the counter would exceed WAIT_MAX: set bus_err, leave pc unchanged, mem_rd<=0, go to IDLE.
- Minimum latency: fetch_req sampled → fetch_valid high 3 edges later (IDLE→ADDR→DATA→IDLE with pulse). Each mem_ready-low cycle adds 1.
- pc_load during ADDR/DATA: capture pc_load_val into the pending register. The latest value wins if pc_load is asserted repeatedly. Apply it on completion as above.
- PC arithmetic is 16-bit modulo: FFFF+1 = 0000, no flag.
- fetch_valid is high for exactly one cycle and cleared in every other state/cycle.
- bus_err blocks new fetches until reset.
- Back-to-back: fetch_req held high starts the next ADDR on the cycle after returning to IDLE.

Optional Feature:
PC_BREAKPOINT_EN: when defined, adds inputs bkpt_addr[15:0] and bkpt_en, and output bkpt_hit. In IDLE, if bkpt_en=1 and pc==bkpt_addr, fetch_req is ignored and bkpt_hit=1 (level, combinational on state/pc/inputs). When undefined, the ports are absent and fetching is never inhibited.

Test Plan:
- Reset, then fetch_req=1 for one cycle with mem_ready=1, mem_data_in=8'h3E → mem_rd high for 2 cycles at addr 0000; data_bus_out=3E; fetch_valid pulses 3 edges after request; pc=0001.
- Fetch with mem_ready low for 2 cycles, WAIT_MAX=4 → fetch_valid delayed by 2 cycles; data latched correctly; bus_err=0.
- mem_ready held low for 5 cycles → bus_err=1, pc unchanged, fetch_valid never asserted; a later fetch_req is ignored.
- pc_load=1, pc_load_val=C000 in IDLE → pc=C000; next fetch drives addr_bus=C000. pc=FFFF fetch → pc=0000.
- pc_load=0150 asserted during DATA of a fetch at 0100 → fetch_valid=0, data_bus_out=00, pc=0150.
- rst asserted during DATA → outputs immediately return to reset values; pc=RESET_PC.
